// File: rtl/ram8.sv
`default_nettype none
// ============================================================================
// Module   : ram8 (with helper modules dmux8way and mux8way16)
// Brief    : 8-word x 16-bit register file. Writes happen on the rising clock
//            edge and are steered by a 1-to-8 load demux. Reads go through
//            mux8way16 and are purely combinational.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// dmux8way : routes a single-bit input to one of eight outputs selected by sel.
// When the input is low, every output is low, regardless of sel.
// ----------------------------------------------------------------------------
module dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic [7:0] out
);

    // Each output is the input gated by a compare against its own index.
    // An unknown sel cannot raise an output while the input is low.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_dec
            localparam logic [2:0] c_IDX = 3'(gi);
            assign out[gi] = in & (sel == c_IDX);
        end
    endgenerate

endmodule

// ----------------------------------------------------------------------------
// mux8way16 : selects one of eight 16-bit inputs (a..h) by sel (0..7).
// ----------------------------------------------------------------------------
module mux8way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);

    // Plain 8:1 select. The default arm keeps the output defined when sel is
    // unknown in simulation.
    always_comb begin
        out = a;
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            3'd7:    out = h;
            default: out = a;
        endcase
    end

endmodule

// ----------------------------------------------------------------------------
// ram8 : top level. Eight independent 16-bit words. The read path has no
// write-through bypass: during a write cycle, out shows the old word until
// the edge.
// ----------------------------------------------------------------------------
module ram8 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic [2:0]  address,
    output logic [15:0] out
);

    localparam int          c_DEPTH = 8;
    localparam logic [15:0] c_ZERO  = 16'h0000;

    logic [7:0]  load_vec;
    logic [15:0] word_q [c_DEPTH];
    logic [15:0] word_d [c_DEPTH];

    // Per-word write enables: at most one is high, and none when load is low.
    dmux8way u_load_demux (
        .in  (load),
        .sel (address),
        .out (load_vec)
    );

    // Next-state for each word: hold, take the write data, or clear on reset.
    // Reset is applied last so that it overrides a simultaneous write.
    always_comb begin
        for (int i = 0; i < c_DEPTH; i++) begin
            word_d[i] = word_q[i];
            if (load_vec[i]) begin
                word_d[i] = in;
            end
            if (reset) begin
                word_d[i] = c_ZERO;
            end
        end
    end

    // Storage registers. The only edge-sensitive state in the block.
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_DEPTH; i++) begin
            word_q[i] <= word_d[i];
        end
    end

    // Combinational read of the addressed word.
    mux8way16 u_read_mux (
        .a   (word_q[0]),
        .b   (word_q[1]),
        .c   (word_q[2]),
        .d   (word_q[3]),
        .e   (word_q[4]),
        .f   (word_q[5]),
        .g   (word_q[6]),
        .h   (word_q[7]),
        .sel (address),
        .out (out)
    );

endmodule
`default_nettype wire

// File: doc/ram8.md
RAM8 -- requirements
Module: ram8

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits and depth at 8 words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in  input  16  write data.
REQ-005 load  input  1  write enable for the addressed word.
REQ-006 address  input  3  word select for both read and write (0..7).
REQ-007 out  output  16  contents of the word selected by address.
REQ-008 One clock (clk); reset is synchronous and active-high (reset); no other clock, enable or asynchronous input SHALL exist.

Function
REQ-009 Storage SHALL be 8 independent 16-bit registers, word[0]..word[7].
REQ-010 Write decode SHALL be a 1-to-8 demultiplexer of load on address.
- Exactly one word's load is asserted when load=1.
- None is asserted when load=0.
REQ-011 Read select SHALL be the team's existing mux8way16 with sel=address and inputs a..h = word[0]..word[7].
REQ-012 Read path SHALL be combinational: out = word[address] within the same cycle address changes, with zero clock latency.
REQ-013 Write SHALL take effect on the rising edge of clk when load=1 and reset=0: word[address] <= in.
REQ-014 Only the addressed word SHALL change on a write; the other 7 words SHALL hold.
REQ-015 When load=0 and reset=0, all words SHALL hold their value indefinitely.
REQ-016 Read-during-write:
- Before the write edge, out SHALL show the old value of word[address] (no write-through bypass).
- After the edge, out SHALL show the new value.
REQ-017 in, load and address SHALL be sampled only at the rising edge for writes; glitches between edges SHALL NOT alter storage.
REQ-018 Writing the same value, or repeated writes to one address on consecutive cycles, SHALL behave as ordinary writes (last write wins).
REQ-019 All 16 bits SHALL be written and read unmodified; no masking, sign handling or arithmetic.
REQ-020 X or Z on address while load=0 SHALL NOT corrupt storage.

Reset
REQ-021 When reset=1 at a rising edge, all 8 words SHALL become 16'h0000 on that edge.
REQ-022 Reset SHALL take priority over load: a simultaneous load write SHALL be discarded.
REQ-023 After reset, out SHALL read 16'h0000 for every address until a word is written.
REQ-024 Reset asserted between write edges SHALL clear all words, including any just written; no partial state SHALL remain.
REQ-025 Reset deasserted SHALL allow a write on the very next rising edge.

Verification
REQ-026 Reset sweep: assert reset for 1 cycle, then sweep address 0..7 with load=0 -> out=16'h0000 at every address.
REQ-027 Fill and readback:
- Stimulus: write 16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789, 16'h789A, 16'h89AB to addresses 0..7, then sweep with load=0.
- Required response: out = the respective value at each address.
REQ-028 Isolation: with the fill above, write 16'hFFFF to address 5 -> address 5 reads 16'hFFFF; addresses 0-4, 6 and 7 are unchanged.
REQ-029 Read-during-write: address=2 holding 16'h3456, in=16'hAAAA, load=1:
- Before the edge -> out=16'h3456.
- After the edge -> out=16'hAAAA.
REQ-030 Reset priority: reset=1, load=1, address=3, in=16'hBEEF at one edge -> out at address 3 = 16'h0000, and all other words = 16'h0000.
REQ-031 Hold: load=0 for 20 cycles while in toggles random values and address sweeps -> every word retains its prior value.
- The bench SHALL compare against a reference array model.
- The bench SHALL log each check to a .out table in the team's standard format.
